// File: rtl/snake_dir_ctrl.sv
// Per-player snake direction controller: press edge-detect, reversal/duplicate filter,
// pending-turn FIFO committed one entry per game tick (with bypass when the queue is empty).
module snake_dir_ctrl #(
   parameter int         NUM_PLAYERS = 1,
   parameter int         QUEUE_DEPTH = 2,
   parameter logic [1:0] INIT_DIR    = 2'b11,
   localparam int        W           = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst_L,
   input  logic                       i_Enable,
   input  logic                       i_Clear,
   input  logic                       i_Tick,
   input  logic [4*NUM_PLAYERS-1:0]   i_Btn,
   output logic [2*NUM_PLAYERS-1:0]   o_Dir,
   output logic [W*NUM_PLAYERS-1:0]   o_Pending,
   output logic [NUM_PLAYERS-1:0]     o_Overflow
);

   localparam int             PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [W-1:0]   FULL = W'(QUEUE_DEPTH);
   localparam logic [PW-1:0]  LAST = PW'(QUEUE_DEPTH - 1);

   logic [4*NUM_PLAYERS-1:0] hist;
   logic [1:0]               dir_q  [NUM_PLAYERS];
   logic [W-1:0]             cnt_q  [NUM_PLAYERS];
   logic [PW-1:0]            rd_q   [NUM_PLAYERS];
   logic [PW-1:0]            wr_q   [NUM_PLAYERS];
   logic [1:0]               mem_q  [NUM_PLAYERS][QUEUE_DEPTH];
   logic [NUM_PLAYERS-1:0]   ovf_q;

   logic [3:0]               new_btn [NUM_PLAYERS];
   logic [1:0]               req_dir [NUM_PLAYERS];
   logic [1:0]               tail    [NUM_PLAYERS];
   logic [PW-1:0]            tail_idx[NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]   accept, pop, push, bypass, drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
      return (v == LAST) ? '0 : v + 1'b1;
   endfunction

   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         new_btn[p] = i_Btn[4*p +: 4] & ~hist[4*p +: 4];
         // Up > Down > Left > Right; bit index equals the direction code
         if (new_btn[p][0])      req_dir[p] = 2'b00;
         else if (new_btn[p][1]) req_dir[p] = 2'b01;
         else if (new_btn[p][2]) req_dir[p] = 2'b10;
         else                    req_dir[p] = 2'b11;

         tail_idx[p] = (wr_q[p] == '0) ? LAST : wr_q[p] - 1'b1;
         tail[p]     = (cnt_q[p] != '0) ? mem_q[p][tail_idx[p]] : dir_q[p];

         accept[p] = i_Enable && !i_Clear && (|new_btn[p]) &&
                     (req_dir[p] != tail[p]) && (req_dir[p] != (tail[p] ^ 2'b01));
         pop[p]    = i_Enable && !i_Clear && i_Tick && (cnt_q[p] != '0);
         bypass[p] = accept[p] && i_Tick && (cnt_q[p] == '0);
         push[p]   = accept[p] && (pop[p] || (!i_Tick && cnt_q[p] != FULL));
         drop[p]   = accept[p] && !i_Tick && (cnt_q[p] == FULL);

         o_Dir[2*p +: 2]     = dir_q[p];
         o_Pending[W*p +: W] = cnt_q[p];
      end
   end

   assign o_Overflow = ovf_q;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         // All ones so buttons held through reset do not register as presses
         hist  <= '1;
         ovf_q <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            dir_q[p] <= INIT_DIR;
            cnt_q[p] <= '0;
            rd_q[p]  <= '0;
            wr_q[p]  <= '0;
         end
      end else begin
         hist <= i_Btn;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            ovf_q[p] <= drop[p];
            if (i_Clear) begin
               dir_q[p] <= INIT_DIR;
               cnt_q[p] <= '0;
               rd_q[p]  <= '0;
               wr_q[p]  <= '0;
            end else begin
               if (pop[p]) begin
                  dir_q[p] <= mem_q[p][rd_q[p]];
                  rd_q[p]  <= ptr_inc(rd_q[p]);
               end else if (bypass[p]) begin
                  dir_q[p] <= req_dir[p];
               end
               if (push[p]) begin
                  mem_q[p][wr_q[p]] <= req_dir[p];
                  wr_q[p]           <= ptr_inc(wr_q[p]);
               end
               if (push[p] && !pop[p])      cnt_q[p] <= cnt_q[p] + 1'b1;
               else if (pop[p] && !push[p]) cnt_q[p] <= cnt_q[p] - 1'b1;
            end
         end
      end
   end

endmodule
